opcode_info_table: RTL and testbench



---
 rtl/opcode_info_table.sv | 177 +++++++++++++++++
 tb/tb_opcode_info_table.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_info_table.sv
// opcode_info_table
//   Writable opcode info table: NUM_MAPS maps of 256 entries (map 0 = one-byte
//   opcodes, map 1 = 0F-escaped). The table zeroes itself after reset or a clear
//   pulse, accepts runtime writes, and serves lookups on a registered
//   valid/ready channel.
//
//   Optional build macro OPINFO_PARITY_EN: stores an even-parity bit per entry
//   and adds the debug input force_par_flip.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   clear                pulse in RUN: re-zero the whole table
//   init_done            table usable (state RUN)
//   wr_en/wr_map/wr_opcode/wr_data, wr_ack     write port, ack one cycle later
//   req_valid/req_ready/req_map/req_opcode/req_tag   lookup request
//   rsp_valid/rsp_ready/rsp_info/rsp_numop/rsp_tag/rsp_err   lookup response
//   force_par_flip       (parity build only) invert parity of next write
module opcode_info_table #(
  parameter int unsigned ENTRY_W  = 23,
  parameter int unsigned NUM_MAPS = 2,
  parameter int unsigned TAG_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  output logic               init_done,
  input  logic               wr_en,
  input  logic [1:0]         wr_map,
  input  logic [7:0]         wr_opcode,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic               wr_ack,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_map,
  input  logic [7:0]         req_opcode,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
`ifdef OPINFO_PARITY_EN
  input  logic               force_par_flip,
`endif
  output logic [ENTRY_W-1:0] rsp_info,
  output logic [1:0]         rsp_numop,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_err
);

  localparam int unsigned DEPTH = NUM_MAPS * 256;
  localparam int unsigned AW    = $clog2(DEPTH);
`ifdef OPINFO_PARITY_EN
  localparam int unsigned MEM_W = ENTRY_W + 1;
`else
  localparam int unsigned MEM_W = ENTRY_W;
`endif
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e             r_state, w_state_d;
  logic [AW-1:0]      r_init_cnt;
  logic [MEM_W-1:0]   r_mem [DEPTH];
  logic               r_wr_ack;
  logic               r_rsp_valid;
  logic [ENTRY_W-1:0] r_rsp_info;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic               r_rsp_err;

  logic               w_wr_map_ok, w_req_map_ok;
  logic               w_wr_accept, w_req_accept;
  logic [AW-1:0]      w_wr_idx, w_req_idx, w_mem_idx;
  logic               w_mem_we;
  logic [MEM_W-1:0]   w_mem_wdata, w_rd_word;
  logic               w_rd_err;

  // Truncation to AW is safe: out-of-range maps never reach the memory.
  assign w_wr_idx     = AW'(32'(wr_map) * 256 + 32'(wr_opcode));
  assign w_req_idx    = AW'(32'(req_map) * 256 + 32'(req_opcode));
  assign w_wr_map_ok  = 32'(wr_map) < NUM_MAPS;
  assign w_req_map_ok = 32'(req_map) < NUM_MAPS;

  assign init_done    = (r_state == StRun);
  assign req_ready    = (r_state == StRun) && (!r_rsp_valid || rsp_ready);
  assign w_req_accept = req_valid && req_ready;
  // A write in the clear cycle would be wiped by INIT anyway, so it is not acked.
  assign w_wr_accept  = (r_state == StRun) && !clear && wr_en && w_wr_map_ok;

  // Single memory write port shared by the init sequencer and the write port.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_wr_idx;
    w_mem_wdata = '0;
    if (r_state == StInit) begin
      w_mem_we  = 1'b1;
      w_mem_idx = r_init_cnt;
    end else if (w_wr_accept) begin
      w_mem_we = 1'b1;
`ifdef OPINFO_PARITY_EN
      w_mem_wdata = {(^wr_data) ^ force_par_flip, wr_data};
`else
      w_mem_wdata = wr_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  // Read-before-write falls out of the registered read of the pre-edge contents.
  assign w_rd_word = r_mem[w_req_idx];
`ifdef OPINFO_PARITY_EN
  assign w_rd_err  = (^w_rd_word[ENTRY_W-1:0]) != w_rd_word[ENTRY_W];
`else
  assign w_rd_err  = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StInit: if (r_init_cnt == LastIdx) w_state_d = StRun;
      StRun:  if (clear) w_state_d = StInit;
      default: w_state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StInit;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StInit) begin
        r_init_cnt <= (r_init_cnt == LastIdx) ? '0 : r_init_cnt + 1'b1;
      end else if (clear) begin
        r_init_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ack    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_info  <= '0;
      r_rsp_tag   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_accept;
      if ((r_state == StRun) && clear) begin
        // Drops the held response and discards a same-cycle accept.
        r_rsp_valid <= 1'b0;
      end else if (w_req_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_tag   <= req_tag;
        if (w_req_map_ok) begin
          r_rsp_info <= w_rd_word[ENTRY_W-1:0];
          r_rsp_err  <= w_rd_err;
        end else begin
          r_rsp_info <= '0;
          r_rsp_err  <= 1'b1;
        end
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign wr_ack    = r_wr_ack;
  assign rsp_valid = r_rsp_valid;
  assign rsp_info  = r_rsp_info;
  assign rsp_numop = r_rsp_info[ENTRY_W-1 -: 2];
  assign rsp_tag   = r_rsp_tag;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_opcode_info_table.sv
module tb_opcode_info_table;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic        init_done;
  logic        wr_en;
  logic [1:0]  wr_map;
  logic [7:0]  wr_opcode;
  logic [22:0] wr_data;
  logic        wr_ack;
  logic        req_valid, req_ready;
  logic [1:0]  req_map;
  logic [7:0]  req_opcode;
  logic [3:0]  req_tag;
  logic        rsp_valid, rsp_ready;
  logic [22:0] rsp_info;
  logic [1:0]  rsp_numop;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        force_par_flip;

  opcode_info_table #(.ENTRY_W(23), .NUM_MAPS(2), .TAG_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .init_done  (init_done),
    .wr_en      (wr_en),
    .wr_map     (wr_map),
    .wr_opcode  (wr_opcode),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_map    (req_map),
    .req_opcode (req_opcode),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
`ifdef OPINFO_PARITY_EN
    .force_par_flip (force_par_flip),
`endif
    .rsp_info   (rsp_info),
    .rsp_numop  (rsp_numop),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [22:0] info;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [22:0] model [4][256];
  logic        model_perr [4][256];
  int          checks = 0;
  int          errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_model();
    for (int m = 0; m < 4; m++) begin
      for (int o = 0; o < 256; o++) begin
        model[m][o]      = '0;
        model_perr[m][o] = 1'b0;
      end
    end
  endtask

  task automatic idle_inputs();
    clear = 0; wr_en = 0; wr_map = 0; wr_opcode = 0; wr_data = 0;
    req_valid = 0; req_map = 0; req_opcode = 0; req_tag = 0;
    rsp_ready = 1; force_par_flip = 0;
  endtask

  task automatic drive_req(input logic [1:0] m, input logic [7:0] op, input logic [3:0] t);
    req_valid = 1; req_map = m; req_opcode = op; req_tag = t;
  endtask

  task automatic drive_wr(input logic [1:0] m, input logic [7:0] op, input logic [22:0] d);
    wr_en = 1; wr_map = m; wr_opcode = op; wr_data = d;
  endtask

  // Scoreboard: expected value pushed at accept, popped at each handshake.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_rsp: got info=%h tag=%0d, required no response",
                   rsp_info, rsp_tag);
        end else begin
          mon_e = sb.pop_front();
          if (rsp_info !== mon_e.info || rsp_tag !== mon_e.tag || rsp_err !== mon_e.err ||
              rsp_numop !== mon_e.info[22:21]) begin
            errors++;
            $display("FAIL sb_rsp: got info=%h numop=%b tag=%0d err=%b, required info=%h numop=%b tag=%0d err=%b",
                     rsp_info, rsp_numop, rsp_tag, rsp_err,
                     mon_e.info, mon_e.info[22:21], mon_e.tag, mon_e.err);
          end
        end
      end
      if (req_valid && req_ready && !clear) begin
        if (req_map < 2'd2) begin
          sb.push_back('{info: model[req_map][req_opcode], tag: req_tag,
                         err: model_perr[req_map][req_opcode]});
        end else begin
          sb.push_back('{info: 23'h0, tag: req_tag, err: 1'b1});
        end
      end
      if (wr_en && init_done && !clear && wr_map < 2'd2) begin
        model[wr_map][wr_opcode]      = wr_data;
        model_perr[wr_map][wr_opcode] = force_par_flip;
      end
    end
  end

  task automatic test_reset();
    int n;
    bit rdy_seen;
    reset = 1;
    idle_inputs();
    tick();
    tick();
    checks++;
    if (init_done !== 0 || wr_ack !== 0 || req_ready !== 0 || rsp_valid !== 0 ||
        rsp_info !== 0 || rsp_tag !== 0 || rsp_err !== 0) begin
      errors++;
      $display("FAIL reset_values: got done=%b ack=%b rdy=%b vld=%b info=%h tag=%0d err=%b, required all 0",
               init_done, wr_ack, req_ready, rsp_valid, rsp_info, rsp_tag, rsp_err);
    end
    reset = 0;
    drive_req(2'd0, 8'h00, 4'd0);
    n = 0;
    rdy_seen = 0;
    while (!init_done && n < 2000) begin
      if (req_ready !== 1'b0) rdy_seen = 1;
      tick();
      n++;
    end
    checks++;
    if (n != 512) begin
      errors++;
      $display("FAIL reset_init_len: got %0d cycles, required 512", n);
    end
    checks++;
    if (rdy_seen) begin
      errors++;
      $display("FAIL reset_ready_in_init: got req_ready=1 during INIT, required 0");
    end
    tick();
    req_valid = 0;
    checks++;
    if (rsp_valid !== 1 || rsp_info !== 23'h0) begin
      errors++;
      $display("FAIL first_lookup: got vld=%b info=%h, required vld=1 info=000000",
               rsp_valid, rsp_info);
    end
    tick();
  endtask

  task automatic test_write_lookup();
    drive_wr(2'd0, 8'h01, 23'h4C3E00);
    tick();
    wr_en = 0;
    checks++;
    if (wr_ack !== 1) begin
      errors++;
      $display("FAIL wr_ack_pulse: got %b, required 1", wr_ack);
    end
    drive_req(2'd0, 8'h01, 4'd5);
    tick();
    req_valid = 0;
    checks++;
    if (wr_ack !== 0) begin
      errors++;
      $display("FAIL wr_ack_single: got %b, required 0", wr_ack);
    end
    checks++;
    if (rsp_valid !== 1 || rsp_info !== 23'h4C3E00 || rsp_numop !== 2'b10 ||
        rsp_tag !== 4'd5 || rsp_err !== 0) begin
      errors++;
      $display("FAIL write_lookup: got vld=%b info=%h numop=%b tag=%0d err=%b, required 1 4c3e00 10 5 0",
               rsp_valid, rsp_info, rsp_numop, rsp_tag, rsp_err);
    end
    tick();
  endtask

  task automatic test_read_before_write();
    drive_wr(2'd1, 8'hAF, 23'h123456);
    drive_req(2'd1, 8'hAF, 4'd7);
    tick();
    wr_en = 0;
    drive_req(2'd1, 8'hAF, 4'd8);
    checks++;
    if (rsp_info !== 23'h0 || wr_ack !== 1) begin
      errors++;
      $display("FAIL rbw_old: got info=%h ack=%b, required info=000000 ack=1", rsp_info, wr_ack);
    end
    tick();
    req_valid = 0;
    checks++;
    if (rsp_info !== 23'h123456) begin
      errors++;
      $display("FAIL rbw_new: got info=%h, required 123456", rsp_info);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int k;
    bit acc;
    logic [3:0] tags [3];
    tags[0] = 4'd10; tags[1] = 4'd11; tags[2] = 4'd12;
    k = 0;
    rsp_ready = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (k < 3) begin
        drive_req(2'd0, 8'h01, tags[k]);
      end else begin
        req_valid = 0;
      end
      if (cyc == 4) rsp_ready = 1;
      @(negedge clk);
      acc = req_valid && req_ready;
      if (cyc >= 1 && cyc <= 3) begin
        checks++;
        if (rsp_valid !== 1 || rsp_tag !== tags[0] || req_ready !== 0 ||
            rsp_info !== 23'h4C3E00) begin
          errors++;
          $display("FAIL bp_hold: cyc %0d got vld=%b tag=%0d rdy=%b info=%h, required 1 %0d 0 4c3e00",
                   cyc, rsp_valid, rsp_tag, req_ready, rsp_info, tags[0]);
        end
      end
      tick();
      if (acc) k++;
    end
    checks++;
    if (k != 3 || sb.size() != 0 || rsp_valid !== 0) begin
      errors++;
      $display("FAIL bp_drain: got accepted=%0d pending=%0d vld=%b, required 3 0 0",
               k, sb.size(), rsp_valid);
    end
  endtask

  task automatic test_bad_map();
    drive_req(2'd2, 8'h01, 4'd9);
    tick();
    req_valid = 0;
    checks++;
    if (rsp_err !== 1 || rsp_info !== 23'h0 || rsp_tag !== 4'd9) begin
      errors++;
      $display("FAIL bad_map_lookup: got err=%b info=%h tag=%0d, required 1 000000 9",
               rsp_err, rsp_info, rsp_tag);
    end
    drive_wr(2'd3, 8'h01, 23'h7FFFFF);
    tick();
    wr_en = 0;
    checks++;
    if (wr_ack !== 0) begin
      errors++;
      $display("FAIL bad_map_write_ack: got %b, required 0", wr_ack);
    end
    drive_req(2'd1, 8'h01, 4'd1);
    tick();
    drive_req(2'd0, 8'h01, 4'd2);
    checks++;
    if (rsp_info !== 23'h0 || rsp_err !== 0) begin
      errors++;
      $display("FAIL bad_map_alias: got info=%h err=%b, required 000000 0", rsp_info, rsp_err);
    end
    tick();
    req_valid = 0;
    tick();
  endtask

`ifdef OPINFO_PARITY_EN
  task automatic test_parity();
    drive_wr(2'd0, 8'h10, 23'h000003);
    force_par_flip = 1;
    tick();
    wr_en = 0;
    force_par_flip = 0;
    drive_req(2'd0, 8'h10, 4'd3);
    tick();
    req_valid = 0;
    checks++;
    if (rsp_err !== 1 || rsp_info !== 23'h000003) begin
      errors++;
      $display("FAIL parity_flip: got err=%b info=%h, required 1 000003", rsp_err, rsp_info);
    end
    tick();
  endtask
`endif

  task automatic test_clear();
    int n;
    clear = 1;
    tick();
    clear = 0;
    zero_model();
    checks++;
    if (init_done !== 0 || rsp_valid !== 0) begin
      errors++;
      $display("FAIL clear_drop: got done=%b vld=%b, required 0 0", init_done, rsp_valid);
    end
    n = 0;
    while (!init_done && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n != 512) begin
      errors++;
      $display("FAIL clear_init_len: got %0d cycles, required 512", n);
    end
    drive_req(2'd0, 8'h01, 4'd4);
    tick();
    drive_req(2'd1, 8'hAF, 4'd6);
    checks++;
    if (rsp_info !== 23'h0) begin
      errors++;
      $display("FAIL clear_zeroed: got info=%h, required 000000", rsp_info);
    end
    tick();
    req_valid = 0;
    tick();
  endtask

  initial begin
    zero_model();
    test_reset();
    test_write_lookup();
    test_read_before_write();
    test_backpressure();
    test_bad_map();
`ifdef OPINFO_PARITY_EN
    test_parity();
`endif
    test_clear();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending responses, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
